cg_enable_ctrl: RTL

Idle-detect clock-gating controller that generates the registered `cg_enable` input of the downstream ICG cell. It watches activity on the gated domain's request interface, removes the clock after a programmable run of idle cycles, and restores it on a wake event. Requests are held off through a warm-up window before the interface accepts them. It runs on the free-running clock upstream of the ICG; `cg_enable` connects directly to the ICG `enable` pin.

---
 rtl/cg_enable_ctrl.sv | 94 +++++++++
 1 files changed

// File: rtl/cg_enable_ctrl.sv
// Idle-detect clock-gating controller: drives the registered ICG enable,
// gates after IDLE_CYCLES idle edges and restores through a WAKE warm-up.
module cg_enable_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             busy_i,
  input  logic             force_on,
  input  logic             req_valid,
  output logic             req_ready,
  output logic             cg_enable,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] gate_count
);

  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int WW = $clog2(WAKE_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
  localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    OFF  = 2'd1,
    WAKE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idle_cnt_q, idle_cnt_d;
  logic [WW-1:0]    wake_cnt_q, wake_cnt_d;
  logic [CNT_W-1:0] gate_count_q, gate_count_d;
  logic             cg_enable_q, cg_enable_d;
  logic             activity;

  assign activity = req_valid | busy_i | force_on;

  always_comb begin
    state_d      = state_q;
    idle_cnt_d   = idle_cnt_q;
    wake_cnt_d   = wake_cnt_q;
    gate_count_d = gate_count_q;
    unique case (state_q)
      RUN: begin
        if (activity) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_LAST) begin
          state_d    = OFF;
          idle_cnt_d = '0;
          if (gate_count_q != '1) gate_count_d = gate_count_q + 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      OFF: begin
        if (activity) begin
          state_d    = WAKE;
          wake_cnt_d = '0;
        end
      end
      WAKE: begin
        // Fixed-length warm-up: inputs neither shorten nor extend it.
        wake_cnt_d = wake_cnt_q + 1'b1;
        if (wake_cnt_q == WAKE_LAST) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    // Enable tracks the next state so it changes on the same edge as the FSM.
    cg_enable_d = (state_d != OFF);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      idle_cnt_q   <= '0;
      wake_cnt_q   <= '0;
      gate_count_q <= '0;
      cg_enable_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      idle_cnt_q   <= idle_cnt_d;
      wake_cnt_q   <= wake_cnt_d;
      gate_count_q <= gate_count_d;
      cg_enable_q  <= cg_enable_d;
    end
  end

  assign req_ready  = (state_q == RUN);
  assign cg_enable  = cg_enable_q;
  assign state_o    = state_q;
  assign gate_count = gate_count_q;

endmodule
